// File: rtl/aud_pkg.sv
// Shared types and constants for the I2S audio output path.
// One stereo frame is 64 BCLK periods: 32 slots per channel.
package aud_pkg;

    localparam int SAMPLE_W_DEF = 16;
    localparam int FRAME_BITS   = 64;
    localparam int HALF_BITS    = 32;

    typedef struct packed {
        logic signed [SAMPLE_W_DEF-1:0] left;
        logic signed [SAMPLE_W_DEF-1:0] right;
    } stereo_t;

endpackage

// File: rtl/aud_sync_fifo.sv
// Single-clock FIFO of stereo frames.
// Reports full/empty/level; pop_data shows the oldest entry combinationally.
module aud_sync_fifo
    import aud_pkg::*;
#(
    parameter int  DEPTH = 16,
    parameter type T     = stereo_t
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  T                       push_data,
    input  logic                   pop,
    output T                       pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    T              mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full     = (level == LW'(DEPTH));
    assign empty    = (level == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/i2s_audio_out.sv
// Stereo PCM to I2S serialiser with frame FIFO, BCLK/LRCK generation and underrun flag.
// Optional I2S_VOL_EN adds a vol_shift port for arithmetic attenuation at frame load.
module i2s_audio_out
    import aud_pkg::*;
#(
    parameter int BCLK_DIV   = 2,
    parameter int SAMPLE_W   = aud_pkg::SAMPLE_W_DEF,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        clk_clk,
    input  logic                        reset_reset,
    input  logic                        enable,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [SAMPLE_W-1:0]         s_left,
    input  logic [SAMPLE_W-1:0]         s_right,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        underrun,
    output logic                        aud_bclk,
    output logic                        aud_daclrck,
    output logic                        aud_dacdat
`ifdef I2S_VOL_EN
    ,
    input  logic [3:0]                  vol_shift
`endif
);

    localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int KW    = $clog2(FRAME_BITS);

    typedef struct packed {
        logic signed [SAMPLE_W-1:0] left;
        logic signed [SAMPLE_W-1:0] right;
    } frame_t;

    logic [DIV_W-1:0]    div_cnt;
    logic [KW-1:0]       bit_cnt;
    logic [KW-1:0]       k_next;
    frame_t              in_frame;
    frame_t              fifo_out;
    frame_t              frame_load;
    frame_t              frame_reg;
    logic                full;
    logic                empty;
    logic                push;
    logic                pop;
    logic                wrap;
    logic                slot;
    logic                dat_next;
    int                  kn;
    logic [SAMPLE_W-1:0] l_sh;
    logic [SAMPLE_W-1:0] r_sh;

    // Sample port handshake: a frame moves when s_valid && s_ready on a clock edge.
    assign s_ready        = !full;
    assign push           = s_valid && !full;
    assign in_frame.left  = s_left;
    assign in_frame.right = s_right;

    assign wrap   = (div_cnt == DIV_W'(BCLK_DIV - 1));
    assign slot   = enable && wrap && aud_bclk;
    assign k_next = bit_cnt + 1'b1;
    assign pop    = slot && (k_next == '0) && !empty;

    aud_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (frame_t)
    ) u_fifo (
        .clk       (clk_clk),
        .reset     (reset_reset),
        .push      (push),
        .push_data (in_frame),
        .pop       (pop),
        .pop_data  (fifo_out),
        .full      (full),
        .empty     (empty),
        .level     (fifo_level)
    );

    always_comb begin
`ifdef I2S_VOL_EN
        frame_load.left  = $signed(fifo_out.left) >>> vol_shift;
        frame_load.right = $signed(fifo_out.right) >>> vol_shift;
`else
        frame_load = fifo_out;
`endif
    end

    // One-bit I2S delay: each channel's MSB goes out one slot after LRCK changes.
    always_comb begin
        dat_next = 1'b0;
        l_sh     = '0;
        r_sh     = '0;
        kn       = int'(k_next);
        if (kn >= 1 && kn <= SAMPLE_W) begin
            l_sh     = frame_reg.left >> (SAMPLE_W - kn);
            dat_next = l_sh[0];
        end else if (kn >= HALF_BITS + 1 && kn <= HALF_BITS + SAMPLE_W) begin
            r_sh     = frame_reg.right >> (SAMPLE_W - (kn - HALF_BITS));
            dat_next = r_sh[0];
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            div_cnt     <= '0;
            bit_cnt     <= KW'(FRAME_BITS - 1);
            frame_reg   <= '0;
            aud_bclk    <= 1'b0;
            aud_daclrck <= 1'b0;
            aud_dacdat  <= 1'b0;
            underrun    <= 1'b0;
        end else if (!enable) begin
            // Parking bit_cnt at the last slot makes the next enabled frame start at k=0.
            div_cnt     <= '0;
            bit_cnt     <= KW'(FRAME_BITS - 1);
            aud_bclk    <= 1'b0;
            aud_daclrck <= 1'b0;
            aud_dacdat  <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            underrun <= 1'b0;
            div_cnt  <= wrap ? '0 : div_cnt + 1'b1;
            if (wrap) begin
                aud_bclk <= !aud_bclk;
            end
            if (slot) begin
                bit_cnt     <= k_next;
                aud_daclrck <= (kn >= HALF_BITS);
                aud_dacdat  <= dat_next;
                if (k_next == '0) begin
                    frame_reg <= empty ? '0 : frame_load;
                    underrun  <= empty;
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_audio_out.sv
// Bench for i2s_audio_out: lockstep reference model of the I2S stream plus directed scenarios.
// The reference tracks clocks since enable and derives BCLK, slot index and frame data arithmetically.
module tb_i2s_audio_out;

    localparam int BCLK_DIV   = 2;
    localparam int SAMPLE_W   = 16;
    localparam int FIFO_DEPTH = 16;
    localparam int SLOT       = 2 * BCLK_DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        s_valid = 1'b0;
    logic [15:0] s_left = '0;
    logic [15:0] s_right = '0;
    logic [3:0]  vol_shift = '0;
    logic        s_ready;
    logic [4:0]  fifo_level;
    logic        underrun;
    logic        aud_bclk;
    logic        aud_daclrck;
    logic        aud_dacdat;

    int n_checks = 0;
    int n_fail   = 0;
    int n_under  = 0;

    always #5 clk = ~clk;

    i2s_audio_out #(
        .BCLK_DIV   (BCLK_DIV),
        .SAMPLE_W   (SAMPLE_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk_clk     (clk),
        .reset_reset (rst),
        .enable      (enable),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_left      (s_left),
        .s_right     (s_right),
        .fifo_level  (fifo_level),
        .underrun    (underrun),
        .aud_bclk    (aud_bclk),
        .aud_daclrck (aud_daclrck),
`ifdef I2S_VOL_EN
        .aud_dacdat  (aud_dacdat),
        .vol_shift   (vol_shift)
`else
        .aud_dacdat  (aud_dacdat)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: queue of frames {left,right}; e = clocks since enable went high.
    logic [31:0] mq[$];
    logic [63:0] stream = '0;
    int          e = 0;
    bit          last_acc = 1'b0;

    // Bit (63-k) of the stream holds the serial value for slot k.
    function automatic logic [63:0] make_stream(input logic [15:0] l, input logic [15:0] r);
        logic [63:0] s;
        s = '0;
        s[62 -: 16] = l;
        s[30 -: 16] = r;
        return s;
    endfunction

    always @(posedge clk) begin
        logic [31:0] f;
        logic [15:0] l;
        logic [15:0] r;
        int          k;
        bit          acc;
        bit          m_under;
        logic        exp_bclk;
        logic        exp_lrck;
        logic        exp_dat;
        acc     = !rst && s_valid && (mq.size() < FIFO_DEPTH);
        m_under = 1'b0;
        if (rst) begin
            mq.delete();
            e      = 0;
            stream = '0;
        end else begin
            if (enable) begin
                e++;
                if (e % SLOT == 0 && (e / SLOT - 1) % 64 == 0) begin
                    if (mq.size() > 0) begin
                        f = mq.pop_front();
                        l = f[31:16];
                        r = f[15:0];
`ifdef I2S_VOL_EN
                        l = 16'($signed(l) >>> vol_shift);
                        r = 16'($signed(r) >>> vol_shift);
`endif
                        stream = make_stream(l, r);
                    end else begin
                        stream  = '0;
                        m_under = 1'b1;
                    end
                end
            end else begin
                e = 0;
            end
            if (acc) mq.push_back({s_left, s_right});
        end
        last_acc = acc;
        exp_bclk = ((e / BCLK_DIV) % 2) == 1;
        if (e >= SLOT) begin
            k        = (e / SLOT - 1) % 64;
            exp_lrck = (k >= 32);
            exp_dat  = stream[6'(63 - k)];
        end else begin
            exp_lrck = 1'b0;
            exp_dat  = 1'b0;
        end
        #1;
        check("bclk", 32'(aud_bclk), 32'(exp_bclk));
        check("lrck", 32'(aud_daclrck), 32'(exp_lrck));
        check("dacdat", 32'(aud_dacdat), 32'(exp_dat));
        check("underrun", 32'(underrun), 32'(m_under));
        check("level", 32'(fifo_level), 32'(mq.size()));
        check("s_ready", 32'(s_ready), 32'(mq.size() < FIFO_DEPTH));
        if (underrun) n_under++;
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic new_data();
        s_left  = 16'($urandom);
        s_right = 16'($urandom);
    endtask

    // Capture one frame's worth of slot values, starting right after enable rises.
    task automatic capture_frame(output logic [63:0] cap);
        cap = '0;
        for (int k = 0; k < 64; k++) begin
            cycles(SLOT);
            cap[6'(63 - k)] = aud_dacdat;
        end
    endtask

    initial begin
        logic [63:0] cap;
        int          rate;

        rst = 1'b1;
        cycles(3);
        check("rst_ready", 32'(s_ready), 32'd1);
        check("rst_level", 32'(fifo_level), 32'd0);
        rst = 1'b0;

        // Known frame, then enable: first slot after enable is k=0.
        s_valid = 1'b1;
        s_left  = 16'hA5C3;
        s_right = 16'h0F01;
        cycles(1);
        s_valid = 1'b0;
        enable  = 1'b1;
        capture_frame(cap);
        check("ser_left", 32'(cap[62:47]), 32'h0000_A5C3);
        check("ser_right", 32'(cap[30:15]), 32'h0000_0F01);
        cycles(256);

        // Empty FIFO while enabled: one underrun per 256 clocks.
        enable = 1'b0;
        cycles(2);
        n_under = 0;
        enable  = 1'b1;
        cycles(1024);
        check("under_count", 32'(n_under), 32'd4);

        // Fill while idle: 16 accepted, the 17th waits.
        enable  = 1'b0;
        cycles(1);
        s_valid = 1'b1;
        new_data();
        for (int i = 0; i < 20; i++) begin
            cycles(1);
            if (last_acc) new_data();
        end
        check("full_level", 32'(fifo_level), 32'd16);
        check("full_ready", 32'(s_ready), 32'd0);
        enable = 1'b1;
        for (int i = 0; i < 600; i++) begin
            cycles(1);
            if (last_acc) new_data();
        end
        s_valid = 1'b0;

        // Reset in the middle of the right half, then re-enable with an empty FIFO.
        enable = 1'b0;
        cycles(1);
        s_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            new_data();
            cycles(1);
        end
        s_valid = 1'b0;
        enable  = 1'b1;
        cycles(SLOT * 41);
        rst = 1'b1;
        cycles(1);
        check("mid_rst_level", 32'(fifo_level), 32'd0);
        check("mid_rst_ready", 32'(s_ready), 32'd1);
        check("mid_rst_lrck", 32'(aud_daclrck), 32'd0);
        rst     = 1'b0;
        n_under = 0;
        cycles(SLOT);
        check("post_rst_under", 32'(n_under), 32'd1);

        // Randomised traffic with occasional enable toggles and resets.
        for (int i = 0; i < 3000; i++) begin
            rate = (i < 1000) ? 20 : (i < 2000) ? 300 : 3;
            if (!s_valid || last_acc) begin
                s_valid = ($urandom_range(0, rate - 1) == 0);
                new_data();
            end
            if ($urandom_range(0, 499) == 0) enable = !enable;
            rst = ($urandom_range(0, 1999) == 0);
            cycles(1);
        end
        rst     = 1'b0;
        s_valid = 1'b0;

`ifdef I2S_VOL_EN
        enable = 1'b0;
        rst    = 1'b1;
        cycles(1);
        rst       = 1'b0;
        vol_shift = 4'd1;
        s_valid   = 1'b1;
        s_left    = 16'h8000;
        s_right   = 16'h7FFE;
        cycles(1);
        s_valid = 1'b0;
        enable  = 1'b1;
        capture_frame(cap);
        check("vol_left", 32'(cap[62:47]), 32'h0000_C000);
        check("vol_right", 32'(cap[30:15]), 32'h0000_3FFF);
`endif

        enable = 1'b0;
        cycles(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
